// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI master transaction controller.
package spi_pkg;

  localparam int unsigned SPI_MAX_BYTES  = 4;
  localparam int unsigned SPI_BYTE_W     = 8;
  localparam int unsigned SPI_DATA_W     = 32;
  localparam int unsigned SPI_BIT_CNT_W  = $clog2(SPI_BYTE_W);
  localparam int unsigned SPI_BYTE_CNT_W = $clog2(SPI_MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_HOLD,
    ST_RESP
  } spi_state_t;

  // Command payload as presented on the command channel.
  typedef struct packed {
    logic [SPI_BYTE_CNT_W-1:0] nbytes;
    logic [SPI_DATA_W-1:0]     tx;
  } spi_cmd_t;

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// Half-period tick generator: counts CLK_DIV cycles per SCLK phase,
// held cleared while clr is high, terminal count on tc_c.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned    CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_MAX);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 transaction controller (1-4 bytes, MSB first).
// Build option: define SPI_LOOPBACK_EN to sample the internal MOSI bit instead of spi_miso.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_nbytes,
  input  logic [31:0] cmd_tx_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rx_data,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // HOLD covers the final SCLK low half-period plus the chip-select hold time.
  localparam int unsigned HOLD_CYC = CLK_DIV + CS_HOLD;
  localparam int unsigned PH_MAX   = (CS_SETUP > HOLD_CYC) ? CS_SETUP : HOLD_CYC;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = SPI_BIT_CNT_W'(SPI_BYTE_W - 1);

  spi_state_t                state;
  spi_cmd_t                  cmd_in_c;
  logic [SPI_BYTE_CNT_W-1:0] nbytes;
  logic [SPI_DATA_W-1:0]     tx_sh;
  logic [SPI_DATA_W-1:0]     rx_sh;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt;
  logic [SPI_BYTE_CNT_W-1:0] byte_cnt;
  logic [PH_W-1:0]           ph_cnt;
  logic                      div_clr_c;
  logic                      half_done_c;
  logic                      rx_bit_c;
  logic                      last_bit_c;

  assign cmd_in_c   = '{nbytes: cmd_nbytes, tx: cmd_tx_data};
  assign last_bit_c = (bit_cnt == BIT_LAST) && (byte_cnt == nbytes);
  assign div_clr_c  = (state != ST_SCK_HI) && (state != ST_SCK_LO);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr_c),
    .tc_c (half_done_c)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso_c;
  assign unused_miso_c = spi_miso;
  assign rx_bit_c      = spi_mosi;
`else
  assign rx_bit_c      = spi_miso;
`endif

  // Controller FSM, counters, shift registers and registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rx_data <= '0;
      spi_sclk    <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_mosi    <= 1'b0;
      nbytes      <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      ph_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            nbytes    <= cmd_in_c.nbytes;
            tx_sh     <= cmd_in_c.tx;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            ph_cnt    <= '0;
            spi_cs_n  <= 1'b0;
            spi_mosi  <= cmd_in_c.tx[SPI_DATA_W-1];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (ph_cnt == SETUP_LAST) begin
            spi_sclk <= 1'b1;
            rx_sh    <= {rx_sh[SPI_DATA_W-2:0], rx_bit_c};
            state    <= ST_SCK_HI;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        ST_SCK_HI: begin
          if (half_done_c) begin
            spi_sclk <= 1'b0;
            if (last_bit_c) begin
              ph_cnt <= '0;
              state  <= ST_HOLD;
            end else begin
              if (bit_cnt == BIT_LAST) begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + SPI_BYTE_CNT_W'(1);
              end else begin
                bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
              end
              tx_sh    <= {tx_sh[SPI_DATA_W-2:0], 1'b0};
              spi_mosi <= tx_sh[SPI_DATA_W-2];
              state    <= ST_SCK_LO;
            end
          end
        end

        ST_SCK_LO: begin
          if (half_done_c) begin
            spi_sclk <= 1'b1;
            rx_sh    <= {rx_sh[SPI_DATA_W-2:0], rx_bit_c};
            state    <= ST_SCK_HI;
          end
        end

        ST_HOLD: begin
          if (ph_cnt == HOLD_LAST) begin
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            rsp_rx_data <= rx_sh;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
